// File: rtl/serial_bit_adder.sv
// serial_bit_adder: unsigned bit-serial adder.
// Both operands are loaded in parallel. The sum is then formed one bit per clock,
// LSB first, through a single full adder and a carry flop.
// Ports:
//   clk        - clock; all state updates on the rising edge
//   reset      - synchronous, active-high; clears all state
//   load       - when sampled high, captures A/B and starts (or restarts) an addition
//   A, B       - WIDTH-bit operands, sampled only on a load edge
//   result     - registered (A+B) mod 2^WIDTH; holds until the next completion
//   carry_out  - registered carry out of the MSB; updates together with result
//   busy       - high while a serial addition is in progress
//   done       - one-cycle pulse in the cycle after result/carry_out update
module serial_bit_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q,     state_d;
  logic [WIDTH-1:0] shreg_a_q,   shreg_a_d;
  logic [WIDTH-1:0] shreg_b_q,   shreg_b_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             carry_q,     carry_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             carry_out_q, carry_out_d;
  logic             busy_q,      busy_d;
  logic             done_pend_q, done_pend_d;
  logic             done_q,      done_d;

  logic sum_bit_c;
  logic carry_nxt_c;

  // Single full adder on the current LSBs
  always_comb begin
    sum_bit_c   = shreg_a_q[0] ^ shreg_b_q[0] ^ carry_q;
    carry_nxt_c = (shreg_a_q[0] & shreg_b_q[0]) |
                  (shreg_a_q[0] & carry_q) |
                  (shreg_b_q[0] & carry_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_a_q   <= '0;
      shreg_b_q   <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_a_q   <= shreg_a_d;
      shreg_b_q   <= shreg_b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    shreg_a_d   = shreg_a_q;
    shreg_b_d   = shreg_b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    count_d     = count_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    busy_d      = busy_q;
    // done trails the result update by one cycle, hence the pending stage
    done_pend_d = 1'b0;
    done_d      = done_pend_q;

    if (load) begin
      // A load always (re)starts; an in-flight addition is dropped silently
      state_d   = RUN;
      shreg_a_d = A;
      shreg_b_d = B;
      sum_d     = '0;
      carry_d   = 1'b0;
      count_d   = '0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          shreg_a_d = shreg_a_q >> 1;
          shreg_b_d = shreg_b_q >> 1;
          carry_d   = carry_nxt_c;
          // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
          sum_d     = {sum_bit_c, sum_q[WIDTH-1:1]};
          count_d   = count_q + CNT_W'(1);
          if (count_q == LAST_BIT) begin
            state_d     = IDLE;
            result_d    = {sum_bit_c, sum_q[WIDTH-1:1]};
            carry_out_d = carry_nxt_c;
            busy_d      = 1'b0;
            done_pend_d = 1'b1;
            count_d     = '0;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_bit_adder.sv
// Directed bench for serial_bit_adder (WIDTH=8).
// Inputs are driven 1ns after a rising edge; outputs are sampled at the same point.
module tb_serial_bit_adder;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] result;
  logic       carry_out;
  logic       busy;
  logic       done;

  int tests;
  int fails;

  serial_bit_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .A         (a),
    .B         (b),
    .result    (result),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse load for one edge with the given operands
  task automatic do_load(input logic [7:0] va, input logic [7:0] vb);
    a    = va;
    b    = vb;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // After a load edge: check busy, result timing, done timing and a single done pulse
  task automatic check_add(input logic [7:0] va, input logic [7:0] vb,
                           input logic [7:0] old_res, input string name);
    logic [8:0] full;
    int         ndone;
    full  = 9'(va) + 9'(vb);
    ndone = 0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_after_load: got %b want 1", name, busy);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    tests++;
    if (result !== old_res || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s hold_before_done: result=%h busy=%b want %h/1", name, result, busy, old_res);
    end
    tick();
    if (done === 1'b1) ndone++;
    tests++;
    if (result !== full[7:0] || carry_out !== full[8] || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s sum: result=%h carry=%b busy=%b want %h/%b/0",
               name, result, carry_out, busy, full[7:0], full[8]);
    end
    tick();
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s done_pulse: got %b want 1", name, done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL %s extra_done: got %0d extra pulses want 0", name, ndone);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (result !== 8'h00 || carry_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset: result=%h carry=%b busy=%b done=%b want 00/0/0/0",
               result, carry_out, busy, done);
    end
  endtask

  task automatic test_basic();
    do_load(8'd7, 8'd3);
    a = 8'hAA;
    b = 8'h55;
    check_add(8'd7, 8'd3, 8'h00, "add_7_3");
  endtask

  task automatic test_reset_clears();
    test_reset();
    do_load(8'd6, 8'd4);
    check_add(8'd6, 8'd4, 8'h00, "add_6_4");
  endtask

  task automatic test_overflow();
    do_load(8'hFF, 8'h01);
    check_add(8'hFF, 8'h01, 8'd10, "ovf_ff_01");
    do_load(8'hFF, 8'hFF);
    check_add(8'hFF, 8'hFF, 8'h00, "ovf_ff_ff");
  endtask

  task automatic test_restart();
    do_load(8'd1, 8'd2);
    tick();
    tick();
    do_load(8'd5, 8'd5);
    check_add(8'd5, 8'd5, 8'hFE, "restart");
  endtask

  task automatic test_held_load();
    a    = 8'd100;
    b    = 8'd50;
    load = 1'b1;
    tick();
    a = 8'd20;
    b = 8'd30;
    tick();
    a = 8'd200;
    b = 8'd90;
    tick();
    load = 1'b0;
    check_add(8'd200, 8'd90, 8'd10, "held_load");
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    ndone = 0;
    do_load(8'd40, 8'd41);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (busy !== 1'b0 || result !== 8'h00 || carry_out !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_run: busy=%b result=%h carry=%b done=%b want 0/00/0/0",
               busy, result, carry_out, done);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    tests++;
    if (ndone != 0 || result !== 8'h00) begin
      fails++;
      $display("FAIL reset_no_done: activity=%0d result=%h want 0/00", ndone, result);
    end
  endtask

  task automatic test_random();
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] prev;
    logic [8:0] full;
    prev = result;
    for (int n = 0; n < 6; n++) begin
      va = 8'($urandom_range(0, 255));
      vb = 8'($urandom_range(0, 255));
      do_load(va, vb);
      a = ~va;
      b = vb ^ 8'h3C;
      check_add(va, vb, prev, "random");
      full = 9'(va) + 9'(vb);
      prev = full[7:0];
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    load  = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    tick();
    test_reset();
    test_basic();
    test_reset_clears();
    test_overflow();
    test_restart();
    test_held_load();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
